seq_restoring_divider: RTL and testbench

- Parametrised multi-cycle unsigned integer divider using the restoring algorithm, one quotient bit per clock.
- Successor to the combinational 4-bit array divider: same shift/subtract/restore datapath, folded into one WIDTH-bit subtractor plus a control FSM.
- Adds a start/busy/done handshake and divide-by-zero detection.
- Used by the ALSU divide operations when WIDTH exceeds the combinational array's practical depth.

---
 rtl/seq_restoring_divider.sv | 172 +++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/busy/done handshake, divide-by-zero flag.
// Optional build macro DIV_SIGNED_EN selects two's-complement (truncating) division on the same datapath.
module seq_restoring_divider #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
   logic             neg_a_q, neg_a_d;
   logic             neg_q_q, neg_q_d;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction
`endif

   logic             accept;
   logic             last_step;
   logic [WIDTH:0]   shifted;
   logic             borrow;
   logic [WIDTH-1:0] p_step;
   logic [WIDTH-1:0] d_step;

   assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign last_step = (state_q == S_CALC) && (cnt_q == '0);

   // The kept remainder is always below B, so it fits in WIDTH bits; the
   // subtraction is taken modulo 2^WIDTH and the borrow from a full compare.
   always_comb begin
      shifted = {p_q, d_q[WIDTH-1]};
      borrow  = (shifted < {1'b0, b_q});
      p_step  = borrow ? shifted[WIDTH-1:0] : (shifted[WIDTH-1:0] - b_q);
      d_step  = {d_q[WIDTH-2:0], ~borrow};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = accept ? S_CALC : S_IDLE;
         S_CALC:  state_d = (cnt_q == '0) ? S_DONE : S_CALC;
         S_DONE:  state_d = accept ? S_CALC : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == S_CALC);
      done = (state_q == S_DONE);
   end

   // A zero divisor is loaded with a zero step count, so it finishes on the next edge.
   always_comb begin
      cnt_d  = cnt_q;
      p_d    = p_q;
      d_d    = d_q;
      b_d    = b_q;
      zero_d = zero_q;
      q_d    = q_q;
      r_d    = r_q;
      dbz_d  = dbz_q;
`ifdef DIV_SIGNED_EN
      neg_a_d = neg_a_q;
      neg_q_d = neg_q_q;
`endif
      if (accept) begin
         cnt_d  = (B == '0) ? '0 : CNT_W'(WIDTH - 1);
         zero_d = (B == '0);
         p_d    = '0;
`ifdef DIV_SIGNED_EN
         d_d     = magnitude(A);
         b_d     = magnitude(B);
         neg_a_d = A[WIDTH-1];
         neg_q_d = A[WIDTH-1] ^ B[WIDTH-1];
`else
         d_d = A;
         b_d = B;
`endif
      end else if (state_q == S_CALC) begin
         cnt_d = cnt_q - 1'b1;
         p_d   = p_step;
         d_d   = d_step;
         if (last_step) begin
            dbz_d = zero_q;
            if (zero_q) begin
               q_d = '1;
`ifdef DIV_SIGNED_EN
               r_d = apply_sign(d_q, neg_a_q);
`else
               r_d = d_q;
`endif
            end else begin
`ifdef DIV_SIGNED_EN
               q_d = apply_sign(d_step, neg_q_q);
               r_d = apply_sign(p_step, neg_a_q);
`else
               q_d = d_step;
               r_d = p_step;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         p_q    <= '0;
         d_q    <= '0;
         b_q    <= '0;
         zero_q <= 1'b0;
         q_q    <= '0;
         r_q    <= '0;
         dbz_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg_a_q <= 1'b0;
         neg_q_q <= 1'b0;
`endif
      end else begin
         cnt_q  <= cnt_d;
         p_q    <= p_d;
         d_q    <= d_d;
         b_q    <= b_d;
         zero_q <= zero_d;
         q_q    <= q_d;
         r_q    <= r_d;
         dbz_q  <= dbz_d;
`ifdef DIV_SIGNED_EN
         neg_a_q <= neg_a_d;
         neg_q_q <= neg_q_d;
`endif
      end
   end

   assign Q           = q_q;
   assign R           = r_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed-vector bench for seq_restoring_divider: WIDTH=8 table plus handshake corner cases,
// and a WIDTH=16 randomised run against a behavioural reference.
module tb_seq_restoring_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        start8, busy8, done8, z8;
   logic [7:0]  a8, b8, q8, r8;
   logic        start16, busy16, done16, z16;
   logic [15:0] a16, b16, q16, r16;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seq_restoring_divider #(.WIDTH(8)) u_div8 (
      .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
      .busy(busy8), .done(done8), .Q(q8), .R(r8), .div_by_zero(z8)
   );

   seq_restoring_divider #(.WIDTH(16)) u_div16 (
      .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16),
      .busy(busy16), .done(done16), .Q(q16), .R(r16), .div_by_zero(z16)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       z;
      int         lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called just after the accepting edge; counts edges until done is seen.
   task automatic wait_done8(output int lat, output int bcnt);
      bcnt = int'(busy8);
      lat  = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (!done8) bcnt += int'(busy8);
      end while (!done8 && lat < 40);
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat, output int bcnt);
      a8 = a; b8 = b; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      wait_done8(lat, bcnt);
   endtask

   initial begin
      int lat, bcnt, extra;
      bit seen;
      logic [15:0] ra, rb, eq, er;
      int sa, sb;

`ifdef DIV_SIGNED_EN
      vecs.push_back('{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 8});
      vecs.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 8});
      vecs.push_back('{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 8});
      vecs.push_back('{8'hF9, 8'hFE, 8'h03, 8'hFF, 1'b0, 8});
      vecs.push_back('{8'h5A, 8'h00, 8'hFF, 8'h5A, 1'b1, 1});
      vecs.push_back('{8'h64, 8'h03, 8'h21, 8'h01, 1'b0, 8});
      vecs.push_back('{8'h80, 8'h00, 8'hFF, 8'h80, 1'b1, 1});
      vecs.push_back('{8'h7F, 8'h01, 8'h7F, 8'h00, 1'b0, 8});
      vecs.push_back('{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 8});
`else
      vecs.push_back('{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8});
      vecs.push_back('{8'h5A,  8'h00,  8'hFF,  8'h5A,  1'b1, 1});
      vecs.push_back('{8'd37,  8'd6,   8'd6,   8'd1,   1'b0, 8});
      vecs.push_back('{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 8});
      vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8});
      vecs.push_back('{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 8});
      vecs.push_back('{8'd255, 8'd2,   8'd127, 8'd1,   1'b0, 8});
      vecs.push_back('{8'd1,   8'd0,   8'hFF,  8'd1,   1'b1, 1});
      vecs.push_back('{8'd128, 8'd16,  8'd8,   8'd0,   1'b0, 8});
`endif

      rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
      start16 = 1'b0; a16 = '0; b16 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy8), 32'd0);
      check("reset_done", 32'(done8), 32'd0);
      check("reset_q", 32'(q8), 32'd0);
      check("reset_r", 32'(r8), 32'd0);
      check("reset_dbz", 32'(z8), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         run8(vecs[i].a, vecs[i].b, lat, bcnt);
         check($sformatf("vec%0d_q", i), 32'(q8), 32'(vecs[i].q));
         check($sformatf("vec%0d_r", i), 32'(r8), 32'(vecs[i].r));
         check($sformatf("vec%0d_dbz", i), 32'(z8), 32'(vecs[i].z));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         if (vecs[i].lat > 1) check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd8);
         @(posedge clk); #1;
         check($sformatf("vec%0d_done_pulse", i), 32'(done8), 32'd0);
      end

      // Back-to-back: new start issued during the DONE cycle.
      run8(8'd5, 8'd9, lat, bcnt);
      check("b2b_first_q", 32'(q8), 32'd0);
      check("b2b_first_r", 32'(r8), 32'd5);
      check("b2b_first_done", 32'(done8), 32'd1);
      a8 = 8'd255; b8 = 8'd1; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      check("b2b_done_low", 32'(done8), 32'd0);
      check("b2b_busy", 32'(busy8), 32'd1);
      wait_done8(lat, bcnt);
      check("b2b_second_q", 32'(q8), 32'd255);
      check("b2b_second_r", 32'(r8), 32'd0);
      check("b2b_second_latency", 32'(lat), 32'd8);
      @(posedge clk); #1;

      // start while busy must be ignored; inputs change after capture.
      a8 = 8'd100; b8 = 8'd3; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
      wait_done8(extra, bcnt);
      check("ignore_q", 32'(q8), 32'd33);
      check("ignore_r", 32'(r8), 32'd1);
      check("ignore_latency", 32'(3 + extra), 32'd8);
      @(posedge clk); #1;

      // Reset in the middle of a computation.
      a8 = 8'd100; b8 = 8'd3; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_busy", 32'(busy8), 32'd0);
      check("midrst_done", 32'(done8), 32'd0);
      check("midrst_q", 32'(q8), 32'd0);
      check("midrst_r", 32'(r8), 32'd0);
      check("midrst_dbz", 32'(z8), 32'd0);
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done8 || busy8) seen = 1'b1;
      end
      check("midrst_no_done", 32'(seen), 32'd0);

      // WIDTH=16 randomised regression against a behavioural reference.
      for (int i = 0; i < 300; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 8 == 0) rb = '0;
         else if (i % 8 == 1) rb = rb & 16'h000F;
`ifdef DIV_SIGNED_EN
         sa = int'($signed(ra));
         sb = int'($signed(rb));
         if (rb == '0) begin eq = '1; er = ra; end
         else begin
            eq = 16'(sa / sb);
            er = 16'(sa % sb);
         end
`else
         sa = 0; sb = 0;
         if (rb == '0) begin eq = '1; er = ra; end
         else begin eq = ra / rb; er = ra % rb; end
`endif
         a16 = ra; b16 = rb; start16 = 1'b1;
         @(posedge clk); #1;
         start16 = 1'b0;
         lat = 0;
         do begin
            @(posedge clk); #1;
            lat++;
         end while (!done16 && lat < 60);
         check($sformatf("w16_%0d_q a=%0h b=%0h", i, ra, rb), 32'(q16), 32'(eq));
         check($sformatf("w16_%0d_r a=%0h b=%0h", i, ra, rb), 32'(r16), 32'(er));
         check($sformatf("w16_%0d_dbz", i), 32'(z16), 32'(rb == '0));
         check($sformatf("w16_%0d_latency", i), 32'(lat), (rb == '0) ? 32'd1 : 32'd16);
         @(posedge clk); #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
